// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan serializer.
// MUX_SCAN_PARITY_EN adds the PARITY state, which sends a ninth parity beat.
package mux_scan_pkg;

    localparam int unsigned WORD_W   = 8;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned LAST_IDX = 7;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;

    // Even parity over the word plus the parity bit itself.
    function automatic logic word_parity(input logic [0:WORD_W-1] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mux8_cell.sv
// Combinational 8:1 select of a word.
// i_sel[0] has weight 1 and i_sel[2] has weight 4.
module mux8_cell
    import mux_scan_pkg::*;
(
    input  logic [0:WORD_W-1] i_data,
    input  logic [0:SEL_W-1]  i_sel,
    output logic              o_y
);

    logic [SEL_W-1:0] w_idx;

    always_comb begin
        for (int i = 0; i < SEL_W; i++) begin
            w_idx[i] = i_sel[i];
        end
        o_y = i_data[w_idx];
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial scanner that owns the word and select lines of an 8:1 mux.
// MUX_SCAN_PARITY_EN adds a ninth even-parity beat after beat 7.
module mux_scan_serializer
    import mux_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [0:WORD_W-1] load_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_data,
    output logic              ser_first,
    output logic              ser_last,
    output logic [0:SEL_W-1]  sel
);

    state_e            r_state;
    logic [SEL_W-1:0]  r_idx;
    logic [0:WORD_W-1] r_word;
    logic [0:SEL_W-1]  w_sel_idx;
    logic              w_mux_y;
    logic              w_idx_last;

    always_comb begin
        for (int i = 0; i < SEL_W; i++) begin
            w_sel_idx[i] = r_idx[i];
        end
        w_idx_last = (r_idx == SEL_W'(LAST_IDX));
    end

    mux8_cell u_mux8_cell (
        .i_data (r_word),
        .i_sel  (w_sel_idx),
        .o_y    (w_mux_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (load_valid) begin
                        r_word  <= load_data;
                        r_idx   <= '0;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    if (ser_ready) begin
                        if (w_idx_last) begin
                            r_idx <= '0;
`ifdef MUX_SCAN_PARITY_EN
                            r_state <= StParity;
`else
                            r_state <= StIdle;
`endif
                        end else begin
                            r_idx <= r_idx + SEL_W'(1);
                        end
                    end
                end
`ifdef MUX_SCAN_PARITY_EN
                StParity: begin
                    if (ser_ready) begin
                        r_state <= StIdle;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs decode from registered state only; ser_ready never reaches load_ready.
    always_comb begin
        load_ready = (r_state == StIdle);
        ser_valid  = 1'b0;
        ser_data   = 1'b0;
        ser_first  = 1'b0;
        ser_last   = 1'b0;
        sel        = '0;
        case (r_state)
            StShift: begin
                ser_valid = 1'b1;
                ser_data  = w_mux_y;
                sel       = w_sel_idx;
                ser_first = (r_idx == '0);
`ifdef MUX_SCAN_PARITY_EN
                ser_last  = 1'b0;
`else
                ser_last  = w_idx_last;
`endif
            end
`ifdef MUX_SCAN_PARITY_EN
            StParity: begin
                ser_valid = 1'b1;
                ser_data  = word_parity(r_word);
                sel       = '1;
                ser_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
